free_slot_alloc: RTL and testbench



---
 rtl/free_slot_alloc_pkg.sv | 14 +
 rtl/free_slot_alloc_first_n_picker.sv | 31 +++
 rtl/free_slot_alloc.sv | 114 +++++++++++
 tb/tb_free_slot_alloc.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/free_slot_alloc_pkg.sv
// Shared helpers for the free-slot allocator: width functions and assertion text.
package free_slot_alloc_pkg;

  function automatic int req_width(input int alloc_width);
    return $clog2(alloc_width + 1);
  endfunction

  function automatic int count_width(input int num_entries);
    return $clog2(num_entries + 1);
  endfunction

  localparam string FreeUnoccMsg = "FREE_UNOCC: release mask names a slot that is not occupied";

endpackage

// File: rtl/free_slot_alloc_first_n_picker.sv
// Combinational picker: mask of the first cnt set bits of free_vec, searching
// upward from start and wrapping modulo N.
module first_n_picker #(
  parameter int N  = 8,
  parameter int CW = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  free_vec,
  input  logic [CW-1:0] cnt,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  mask
);

  int idx;
  int taken;

  always_comb begin
    mask  = '0;
    idx   = 0;
    taken = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (free_vec[idx] && (taken < int'(cnt))) begin
        mask[idx] = 1'b1;
        taken     = taken + 1;
      end
    end
  end

endmodule

// File: rtl/free_slot_alloc.sv
// Multi-hot slot allocator: grants N free slots per cycle, accepts release masks.
// Build option FREE_SLOT_ALLOC_ROUND_ROBIN_EN starts the free search at a rotating pointer.
module free_slot_alloc
  import free_slot_alloc_pkg::*;
#(
  parameter int NumEntries = 8,
  parameter int AllocWidth = 2,
  parameter int ReqWidth   = req_width(AllocWidth),
  parameter int CountWidth = count_width(NumEntries)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_valid_i,
  input  logic [ReqWidth-1:0]   alloc_cnt_i,
  output logic                  alloc_ready_o,
  output logic [NumEntries-1:0] alloc_mask_o,
  input  logic                  free_valid_i,
  input  logic [NumEntries-1:0] free_mask_i,
  input  logic                  flush_i,
  output logic [CountWidth-1:0] free_cnt_o,
  output logic [NumEntries-1:0] occ_o
);

  // Handshake: alloc_ready_o depends only on alloc_cnt_i and the registered
  // free count; a grant happens when alloc_valid_i and alloc_ready_o are both high.
  logic [NumEntries-1:0] occ_q, occ_d;
  logic [CountWidth-1:0] free_cnt_q, free_cnt_d;
  logic [NumEntries-1:0] pick_mask;
  logic                  cnt_legal;
  logic                  fire;

  assign cnt_legal     = int'(alloc_cnt_i) <= AllocWidth;
  assign alloc_ready_o = cnt_legal && (int'(free_cnt_q) >= int'(alloc_cnt_i));
  assign fire          = alloc_valid_i && alloc_ready_o;
  assign alloc_mask_o  = fire ? pick_mask : '0;

`ifdef FREE_SLOT_ALLOC_ROUND_ROBIN_EN
  localparam int PtrWidth = $clog2(NumEntries);
  logic [PtrWidth-1:0] ptr_q, ptr_d;
  int                  rr_idx;
  int                  rr_last;

  first_n_picker #(.N(NumEntries), .CW(ReqWidth)) u_picker (
    .free_vec (~occ_q),
    .cnt      (alloc_cnt_i),
    .start    (ptr_q),
    .mask     (pick_mask)
  );

  // The pointer follows the last slot granted in search order, not the highest index.
  always_comb begin
    ptr_d   = ptr_q;
    rr_idx  = 0;
    rr_last = int'(ptr_q);
    if (flush_i) begin
      ptr_d = '0;
    end else if (fire && (alloc_cnt_i != '0)) begin
      for (int i = 0; i < NumEntries; i++) begin
        rr_idx = int'(ptr_q) + i;
        if (rr_idx >= NumEntries) rr_idx = rr_idx - NumEntries;
        if (alloc_mask_o[rr_idx]) rr_last = rr_idx;
      end
      ptr_d = PtrWidth'((rr_last + 1) % NumEntries);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  first_n_picker #(.N(NumEntries), .CW(ReqWidth)) u_picker (
    .free_vec (~occ_q),
    .cnt      (alloc_cnt_i),
    .start    ('0),
    .mask     (pick_mask)
  );
`endif

  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else begin
      occ_d = (occ_q & ~(free_valid_i ? free_mask_i : '0)) | alloc_mask_o;
    end
  end

  // Count-one of ~occ_d so the registered count always agrees with occ_o.
  always_comb begin
    free_cnt_d = '0;
    for (int i = 0; i < NumEntries; i++) begin
      free_cnt_d = free_cnt_d + CountWidth'(!occ_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q      <= '0;
      free_cnt_q <= CountWidth'(NumEntries);
    end else begin
      occ_q      <= occ_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign occ_o      = occ_q;
  assign free_cnt_o = free_cnt_q;

  a_free_unocc: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(free_valid_i && !flush_i && |(free_mask_i & ~occ_q)))
    else $error("%s", FreeUnoccMsg);

endmodule

// File: tb/tb_free_slot_alloc.sv
// Directed bench for free_slot_alloc (NumEntries=8, AllocWidth=2) with an expected-value queue.
module tb_free_slot_alloc;

  localparam int W = 21;

  logic       clk;
  logic       rst_n;
  logic       alloc_valid;
  logic [1:0] alloc_cnt;
  logic       alloc_ready;
  logic [7:0] alloc_mask;
  logic       free_valid;
  logic [7:0] free_mask;
  logic       flush;
  logic [3:0] free_cnt;
  logic [7:0] occ;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  free_slot_alloc #(.NumEntries(8), .AllocWidth(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alloc_valid_i (alloc_valid),
    .alloc_cnt_i   (alloc_cnt),
    .alloc_ready_o (alloc_ready),
    .alloc_mask_o  (alloc_mask),
    .free_valid_i  (free_valid),
    .free_mask_i   (free_mask),
    .flush_i       (flush),
    .free_cnt_o    (free_cnt),
    .occ_o         (occ)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: inputs change 1 time unit after the rising edge
  task automatic step(input logic v, input logic [1:0] c, input logic fv,
                      input logic [7:0] fm, input logic fl,
                      input logic er, input logic [7:0] em,
                      input logic [7:0] eo, input logic [3:0] ef);
    @(posedge clk);
    #1;
    alloc_valid = v;
    alloc_cnt   = c;
    free_valid  = fv;
    free_mask   = fm;
    flush       = fl;
    exp_q.push_back({er, em, eo, ef});
  endtask

  task automatic idle(input logic er, input logic [7:0] eo, input logic [3:0] ef);
    step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, er, 8'h00, eo, ef);
  endtask

  // monitor / scoreboard: compare on the falling edge
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {alloc_ready, alloc_mask, occ, free_cnt};
        step_no++;
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL step%0d got ready=%b mask=%h occ=%h free_cnt=%0d expected ready=%b mask=%h occ=%h free_cnt=%0d",
                   step_no, got[20], got[19:12], got[11:4], got[3:0],
                   e[20], e[19:12], e[11:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    alloc_cnt   = 2'd0;
    free_valid  = 1'b0;
    free_mask   = 8'h00;
    flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef FREE_SLOT_ALLOC_ROUND_ROBIN_EN
    idle(1'b1, 8'h00, 4'd8);
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h00, 4'd8);
    step(1'b0, 2'd0, 1'b1, 8'h03, 1'b0, 1'b1, 8'h00, 8'h03, 4'd6);
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0C, 8'h00, 4'd8);
    step(1'b1, 2'd1, 1'b1, 8'h0C, 1'b0, 1'b1, 8'h10, 8'h0C, 4'd6);
    step(1'b1, 2'd2, 1'b1, 8'h10, 1'b0, 1'b1, 8'h60, 8'h10, 4'd7);
    step(1'b0, 2'd0, 1'b1, 8'h60, 1'b0, 1'b1, 8'h00, 8'h60, 4'd6);
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h81, 8'h00, 4'd8);
    idle(1'b1, 8'h81, 4'd6);
`else
    idle(1'b1, 8'h00, 4'd8);                                           // reset state
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h00, 4'd8);
    idle(1'b1, 8'h03, 4'd6);
    step(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03, 4'd6);     // illegal count
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0C, 8'h03, 4'd6);
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h30, 8'h0F, 4'd4);
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC0, 8'h3F, 4'd2);
    step(1'b0, 2'd0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 8'hFF, 4'd0);
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFE, 4'd1);     // not enough room
    step(1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'hFE, 4'd1);
    step(1'b1, 2'd1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'hFF, 4'd0);     // full, no bypass
    step(1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'hEF, 4'd1);
    step(1'b0, 2'd0, 1'b1, 8'hF0, 1'b0, 1'b1, 8'h00, 8'hFF, 4'd0);
    step(1'b1, 2'd2, 1'b1, 8'h03, 1'b0, 1'b1, 8'h30, 8'h0F, 4'd4);     // alloc + free together
    step(1'b1, 2'd2, 1'b1, 8'h04, 1'b1, 1'b1, 8'h03, 8'h3C, 4'd4);     // flush wins
    step(1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00, 4'd8);
    step(1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 8'h01, 4'd7);
    idle(1'b1, 8'h07, 4'd5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    idle(1'b1, 8'h00, 4'd8);                                           // after async reset
    step(1'b0, 2'd2, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 4'd8);     // ready without valid
`endif

    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    alloc_cnt   = 2'd0;
    free_valid  = 1'b0;
    flush       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
